// File: rtl/arb_mux_rr_pkg.sv
// Shared types and constants for the arb_mux_rr multiplexer and its rr_arbiter.
package arb_mux_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_e;

  typedef enum logic {
    LOCK_OPEN = 1'b0,
    LOCK_HELD = 1'b1
  } lock_e;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_DATA_W = 32;

  // Channel-index width; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_rr_if.sv
// Requester-side and consumer-side handshake bundle of arb_mux_rr; signal names are from the mux's view.
interface arb_mux_rr_if
  import arb_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  localparam int unsigned SEL_W = idx_w(NUM_CH);

  logic [NUM_CH-1:0]        valid_i;
  logic [NUM_CH*DATA_W-1:0] data_i;
  logic [NUM_CH-1:0]        ready_o;
  logic                     valid_o;
  logic [DATA_W-1:0]        data_o;
  logic [SEL_W-1:0]         sel_o;
  logic                     ready_i;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, sel_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, sel_o
  );

endinterface

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr wins, wrapping past the top channel.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned SEL_W  = idx_w(DEF_NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  int unsigned      c;
  logic [SEL_W-1:0] ci;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a latch behind.
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    ci  = '0;
    if (en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        c = 32'(ptr) + 32'(i);
        if (c >= NUM_CH) c = c - NUM_CH;
        ci = SEL_W'(c);
        if (!any && req[ci]) begin
          gnt[ci] = 1'b1;
          idx     = ci;
          any     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arb_mux_rr.sv
// N-channel valid/ready mux with round-robin or fixed selection and a registered output stage.
// Define ARB_MUX_LOCK_EN to let a requester hold its grant across beats via lock_i.
module arb_mux_rr
  import arb_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      mode_i,
  input  logic [idx_w(NUM_CH)-1:0]  sel_i,
  input  logic                      lock_i,
  arb_mux_rr_if.slave               bus
);

  localparam int unsigned      SEL_W   = idx_w(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  mode_e             mode;
  logic              load;
  logic [NUM_CH-1:0] mode_mask, lock_mask, req, gnt;
  logic [SEL_W-1:0]  gnt_idx, ptr_q, ptr_d;
  logic              gnt_any, ptr_hold, ptr_adv;

  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (i == SEL_W'(k)) v[k] = 1'b1;
    return v;
  endfunction

  assign mode = mode_e'(mode_i);
  assign load = !bus.valid_o || bus.ready_i;

  // An out-of-range sel_i decodes to no bit at all, so fixed mode grants nothing.
  assign mode_mask = (mode == MODE_FIXED) ? onehot(sel_i) : '1;
  assign req       = bus.valid_i & mode_mask & lock_mask;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .en  (load && rst_ni),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign bus.ready_o = gnt;
  assign ptr_d       = (gnt_idx == LAST_CH) ? '0 : gnt_idx + SEL_W'(1);
  assign ptr_adv     = gnt_any && (mode == MODE_RR) && !ptr_hold;

`ifdef ARB_MUX_LOCK_EN
  lock_e            lock_q, lock_d;
  logic [SEL_W-1:0] lock_ch_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= LOCK_OPEN;
      lock_ch_q <= '0;
    end else begin
      lock_q <= lock_d;
      if (gnt_any) lock_ch_q <= gnt_idx;
    end
  end

  always_comb begin
    lock_d = lock_q;
    if (gnt_any) lock_d = lock_i ? LOCK_HELD : LOCK_OPEN;
  end

  // While held, only the owner may win; its releasing beat still advances the pointer.
  always_comb begin
    lock_mask = '1;
    ptr_hold  = 1'b0;
    if (lock_q == LOCK_HELD) begin
      lock_mask = onehot(lock_ch_q);
      ptr_hold  = lock_i;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = lock_i;
  assign lock_mask   = '1;
  assign ptr_hold    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.valid_o <= 1'b0;
      bus.data_o  <= '0;
      bus.sel_o   <= '0;
      ptr_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (gnt_any) begin
        bus.valid_o <= 1'b1;
        bus.data_o  <= bus.data_i[gnt_idx*DATA_W +: DATA_W];
        bus.sel_o   <= gnt_idx;
      end else if (bus.ready_i) begin
        bus.valid_o <= 1'b0;
      end
      if (ptr_adv) ptr_q <= ptr_d;
    end
  end

endmodule

// File: tb/tb_arb_mux_rr.sv
// Self-checking bench for arb_mux_rr: directed scenarios on a 4- and a 3-channel instance,
// plus randomized traffic against a rule-level reference model (lock rules when ARB_MUX_LOCK_EN).
module tb_arb_mux_rr;

  localparam int N4 = 4, W4 = 32, N3 = 3, W3 = 16;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       mode4, lock4, mode3, lock3;
  logic [1:0] sel4, sel3;

  arb_mux_rr_if #(.NUM_CH(N4), .DATA_W(W4)) bus4 ();
  arb_mux_rr_if #(.NUM_CH(N3), .DATA_W(W3)) bus3 ();

  arb_mux_rr #(.NUM_CH(N4), .DATA_W(W4)) dut4 (
    .clk_i (clk_i), .rst_ni (rst_ni), .mode_i (mode4), .sel_i (sel4), .lock_i (lock4),
    .bus   (bus4.slave)
  );

  arb_mux_rr #(.NUM_CH(N3), .DATA_W(W3)) dut3 (
    .clk_i (clk_i), .rst_ni (rst_ni), .mode_i (mode3), .sel_i (sel3), .lock_i (lock3),
    .bus   (bus3.slave)
  );

  int checks = 0;
  int errors = 0;

  // Upstream contract: a pending request and its payload hold until accepted.
  logic [N4-1:0]    prev_pend = '0;
  logic [N4*W4-1:0] prev_data = '0;
  always @(posedge clk_i) begin
    if (rst_ni) begin
      for (int k = 0; k < N4; k++)
        if (prev_pend[k])
          assert (bus4.valid_i[k] && bus4.data_i[k*W4 +: W4] == prev_data[k*W4 +: W4])
            else $error("upstream contract broken on channel %0d", k);
    end
    prev_pend <= rst_ni ? (bus4.valid_i & ~bus4.ready_o) : '0;
    prev_data <= bus4.data_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    bus4.valid_i = '0; bus4.ready_i = 1'b0; mode4 = 1'b0; sel4 = '0; lock4 = 1'b0;
    bus3.valid_i = '0; bus3.ready_i = 1'b0; mode3 = 1'b0; sel3 = '0; lock3 = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  // ---------------- reference model (4-channel instance) ----------------
  logic        m_valid;
  logic [1:0]  m_sel;
  logic [31:0] m_data;
  int          m_ptr;
  bit          m_locked;
  int          m_lock_ch;

  task automatic model_reset();
    m_valid = 1'b0; m_sel = '0; m_data = '0; m_ptr = 0; m_locked = 1'b0; m_lock_ch = 0;
  endtask

  function automatic int model_grant();
    int g = -1;
    if (m_valid && !bus4.ready_i) return -1;
    if (mode4) begin
      if (int'(sel4) < N4 && bus4.valid_i[sel4] && (!m_locked || int'(sel4) == m_lock_ch))
        g = int'(sel4);
    end else begin
      for (int i = 0; i < N4; i++) begin
        int c = (m_ptr + i) % N4;
        if (g < 0 && bus4.valid_i[c] && (!m_locked || c == m_lock_ch)) g = c;
      end
    end
    return g;
  endfunction

  task automatic model_step(input int g);
    if (g >= 0) begin
      if (!mode4 && !(m_locked && lock4)) m_ptr = (g + 1) % N4;
`ifdef ARB_MUX_LOCK_EN
      m_locked  = lock4;
      m_lock_ch = g;
`endif
      m_valid = 1'b1;
      m_data  = bus4.data_i[g*W4 +: W4];
      m_sel   = 2'(g);
    end else if (bus4.ready_i) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus4.valid_i = 4'b1111;
    tick();
    checks++;
    if ({bus4.valid_o, bus4.sel_o, bus4.data_o, bus4.ready_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b s=%0d d=%h r=%b want all zero",
               bus4.valid_o, bus4.sel_o, bus4.data_o, bus4.ready_o);
    end
    bus4.valid_i = '0;
    rst_ni = 1'b1;
    tick();

    // single transfer on channel 2
    for (int k = 0; k < N4; k++) bus4.data_i[k*W4 +: W4] = $urandom;
    bus4.data_i[2*W4 +: W4] = 32'hDEADBEEF;
    bus4.valid_i = 4'b0100;
    bus4.ready_i = 1'b1;
    settle();
    checks++;
    if (bus4.ready_o !== 4'b0100) begin
      errors++; $display("FAIL basic_ready: got %b want 0100", bus4.ready_o);
    end
    tick();
    checks++;
    if ({bus4.valid_o, bus4.sel_o, bus4.data_o} !== {1'b1, 2'd2, 32'hDEADBEEF}) begin
      errors++; $display("FAIL basic_out: got v=%b s=%0d d=%h want v=1 s=2 d=deadbeef",
                         bus4.valid_o, bus4.sel_o, bus4.data_o);
    end

    // load channel 1, then assert reset while ch2 is pending and the output is held
    bus4.valid_i = 4'b0010;
    bus4.data_i[1*W4 +: W4] = 32'h12345678;
    tick();
    bus4.valid_i = 4'b0100;
    bus4.ready_i = 1'b0;
    settle();
    checks++;
    if ({bus4.valid_o, bus4.sel_o, bus4.data_o} !== {1'b1, 2'd1, 32'h12345678}) begin
      errors++; $display("FAIL held_before_reset: got v=%b s=%0d d=%h want v=1 s=1 d=12345678",
                         bus4.valid_o, bus4.sel_o, bus4.data_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({bus4.valid_o, bus4.sel_o, bus4.data_o, bus4.ready_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b s=%0d d=%h r=%b want all zero",
               bus4.valid_o, bus4.sel_o, bus4.data_o, bus4.ready_o);
    end
    bus4.valid_i = '0;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_rr_fairness();
    logic [31:0] d;
    do_reset();
    for (int k = 0; k < N4; k++) bus4.data_i[k*W4 +: W4] = $urandom;
    bus4.valid_i = 4'b1111;
    bus4.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      checks++;
      if (bus4.ready_o !== 4'(1 << (i % N4))) begin
        errors++; $display("FAIL rr_ready beat %0d: got %b want %b", i, bus4.ready_o, 4'(1 << (i % N4)));
      end
      d = bus4.data_i[(i % N4)*W4 +: W4];
      tick();
      checks++;
      if ({bus4.valid_o, bus4.sel_o, bus4.data_o} !== {1'b1, 2'(i % N4), d}) begin
        errors++; $display("FAIL rr_out beat %0d: got s=%0d d=%h want s=%0d d=%h",
                           i, bus4.sel_o, bus4.data_o, i % N4, d);
      end
      bus4.data_i[(i % N4)*W4 +: W4] = $urandom;
    end

    // pointer at 1 after a channel-0 beat; then 1001 must grant 3 before 0
    do_reset();
    bus4.ready_i = 1'b1;
    bus4.valid_i = 4'b0001;
    tick();
    bus4.valid_i = 4'b1001;
    settle();
    checks++;
    if (bus4.ready_o !== 4'b1000) begin
      errors++; $display("FAIL rr_wrap_first: got %b want 1000", bus4.ready_o);
    end
    tick();
    settle();
    checks++;
    if (bus4.ready_o !== 4'b0001 || bus4.sel_o !== 2'd3) begin
      errors++; $display("FAIL rr_wrap_second: got r=%b s=%0d want r=0001 s=3", bus4.ready_o, bus4.sel_o);
    end
    tick();
    checks++;
    if (bus4.sel_o !== 2'd0) begin
      errors++; $display("FAIL rr_wrap_out: got s=%0d want 0", bus4.sel_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus4.data_i[0*W4 +: W4] = 32'hA5A50001;
    bus4.valid_i = 4'b0001;
    bus4.ready_i = 1'b1;
    tick();
    bus4.valid_i = 4'b0010;
    bus4.data_i[1*W4 +: W4] = 32'hB0B00002;
    bus4.ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if (bus4.ready_o !== 4'b0000) begin
        errors++; $display("FAIL bp_ready cycle %0d: got %b want 0000", i, bus4.ready_o);
      end
      tick();
      checks++;
      if ({bus4.valid_o, bus4.sel_o, bus4.data_o} !== {1'b1, 2'd0, 32'hA5A50001}) begin
        errors++; $display("FAIL bp_hold cycle %0d: got v=%b s=%0d d=%h want v=1 s=0 d=a5a50001",
                           i, bus4.valid_o, bus4.sel_o, bus4.data_o);
      end
    end
    bus4.ready_i = 1'b1;
    settle();
    checks++;
    if (bus4.ready_o !== 4'b0010) begin
      errors++; $display("FAIL bp_release_ready: got %b want 0010", bus4.ready_o);
    end
    tick();
    checks++;
    if ({bus4.valid_o, bus4.sel_o, bus4.data_o} !== {1'b1, 2'd1, 32'hB0B00002}) begin
      errors++; $display("FAIL bp_back_to_back: got v=%b s=%0d d=%h want v=1 s=1 d=b0b00002",
                         bus4.valid_o, bus4.sel_o, bus4.data_o);
    end
  endtask

  task automatic test_fixed();
    logic [31:0] d;
    do_reset();
    for (int k = 0; k < N4; k++) bus4.data_i[k*W4 +: W4] = $urandom;
    mode4 = 1'b1;
    sel4  = 2'd1;
    bus4.valid_i = 4'b0111;
    bus4.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (bus4.ready_o !== 4'b0010) begin
        errors++; $display("FAIL fixed_ready beat %0d: got %b want 0010", i, bus4.ready_o);
      end
      d = bus4.data_i[1*W4 +: W4];
      tick();
      checks++;
      if ({bus4.valid_o, bus4.sel_o, bus4.data_o} !== {1'b1, 2'd1, d}) begin
        errors++; $display("FAIL fixed_out beat %0d: got s=%0d d=%h want s=1 d=%h", i, bus4.sel_o, bus4.data_o, d);
      end
      bus4.data_i[1*W4 +: W4] = $urandom;
    end
    // back in round-robin the untouched pointer still favours channel 0
    mode4 = 1'b0;
    settle();
    checks++;
    if (bus4.ready_o !== 4'b0001) begin
      errors++; $display("FAIL fixed_ptr_kept: got %b want 0001", bus4.ready_o);
    end
    d = bus4.data_i[0*W4 +: W4];
    tick();
    bus4.valid_i = 4'b0110;
    mode4 = 1'b1;
    sel4  = 2'd3;
    settle();
    checks++;
    if (bus4.ready_o !== 4'b0000) begin
      errors++; $display("FAIL fixed_no_valid: got %b want 0000", bus4.ready_o);
    end
    tick();
    checks++;
    if ({bus4.valid_o, bus4.sel_o, bus4.data_o} !== {1'b0, 2'd0, d}) begin
      errors++; $display("FAIL fixed_drain: got v=%b s=%0d d=%h want v=0 s=0 d=%h",
                         bus4.valid_o, bus4.sel_o, bus4.data_o, d);
    end
  endtask

`ifdef ARB_MUX_LOCK_EN
  task automatic test_lock();
    logic [3:0] exp_r;
    do_reset();
    for (int k = 0; k < N4; k++) bus4.data_i[k*W4 +: W4] = $urandom;
    bus4.valid_i = 4'b1111;
    bus4.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lock4 = (i < 3);
      exp_r = (i < 4) ? 4'b0001 : 4'b0010;
      settle();
      checks++;
      if (bus4.ready_o !== exp_r) begin
        errors++; $display("FAIL lock_ready beat %0d: got %b want %b", i, bus4.ready_o, exp_r);
      end
      tick();
      bus4.data_i[((i < 4) ? 0 : 1)*W4 +: W4] = $urandom;
    end
    checks++;
    if (bus4.sel_o !== 2'd1) begin
      errors++; $display("FAIL lock_release_out: got s=%0d want 1", bus4.sel_o);
    end
  endtask
`endif

  task automatic test_non_pow2();
    logic [15:0] d;
    int e;
    do_reset();
    for (int k = 0; k < N3; k++) bus3.data_i[k*W3 +: W3] = 16'($urandom);
    bus3.valid_i = 3'b111;
    bus3.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = i % N3;
      settle();
      checks++;
      if (bus3.ready_o !== 3'(1 << e)) begin
        errors++; $display("FAIL np2_ready beat %0d: got %b want %b", i, bus3.ready_o, 3'(1 << e));
      end
      d = bus3.data_i[e*W3 +: W3];
      tick();
      checks++;
      if ({bus3.valid_o, bus3.sel_o, bus3.data_o} !== {1'b1, 2'(e), d}) begin
        errors++; $display("FAIL np2_out beat %0d: got s=%0d d=%h want s=%0d d=%h", i, bus3.sel_o, bus3.data_o, e, d);
      end
      bus3.data_i[e*W3 +: W3] = 16'($urandom);
    end
    mode3 = 1'b1;
    sel3  = 2'd3;
    settle();
    checks++;
    if (bus3.ready_o !== 3'b000) begin
      errors++; $display("FAIL np2_sel_out_of_range: got %b want 000", bus3.ready_o);
    end
    tick();
    checks++;
    if (bus3.valid_o !== 1'b0) begin
      errors++; $display("FAIL np2_no_accept: got v=%b want 0", bus3.valid_o);
    end
  endtask

  task automatic test_random();
    int g = -1;
    logic [3:0] exp_r;
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < N4; k++)
        if (!bus4.valid_i[k] || g == k) begin
          bus4.valid_i[k] = 1'($urandom_range(0, 1));
          bus4.data_i[k*W4 +: W4] = $urandom;
        end
      bus4.ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) mode4 = ~mode4;
      sel4  = 2'($urandom_range(0, 3));
      lock4 = ($urandom_range(0, 3) == 0);
      settle();
      g = model_grant();
      exp_r = (g >= 0) ? 4'(1 << g) : 4'b0000;
      checks++;
      if (bus4.ready_o !== exp_r) begin
        errors++; $display("FAIL rand_ready cycle %0d: got %b want %b", n, bus4.ready_o, exp_r);
      end
      tick();
      model_step(g);
      checks++;
      if ({bus4.valid_o, bus4.sel_o, bus4.data_o} !== {m_valid, m_sel, m_data}) begin
        errors++; $display("FAIL rand_out cycle %0d: got v=%b s=%0d d=%h want v=%b s=%0d d=%h",
                           n, bus4.valid_o, bus4.sel_o, bus4.data_o, m_valid, m_sel, m_data);
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    bus4.valid_i = '0; bus4.data_i = '0; bus4.ready_i = 1'b0;
    bus3.valid_i = '0; bus3.data_i = '0; bus3.ready_i = 1'b0;
    mode4 = 1'b0; sel4 = '0; lock4 = 1'b0;
    mode3 = 1'b0; sel3 = '0; lock3 = 1'b0;
    test_reset();
    test_rr_fairness();
    test_backpressure();
    test_fixed();
`ifdef ARB_MUX_LOCK_EN
    test_lock();
`endif
    test_non_pow2();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
